otp_word_sequencer: RTL

- Clocked front-end stage placed directly upstream of the one-time-pad encrypt/decrypt block.
- Packs an incoming byte stream into 16-bit words.
- Drives the encrypt block's level start/done handshake through synchronizers, captures the result, and presents encrypted words on a ready/valid output port.
- Provides a bypass path, a handshake timeout and a sticky error flag.

---
 rtl/otp_word_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/otp_word_sequencer.sv
// Byte-to-word packer that drives the one-time-pad encrypt block over a synchronized
// level start/done handshake and presents results (or bypassed words) on a ready/valid port.
module otp_word_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  input  logic        bypass,
  output logic [15:0] enc_data_o,
  output logic        enc_start_o,
  output logic        enc_passthrough_o,
  input  logic [15:0] enc_result_i,
  input  logic        enc_done_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        out_last,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL_LO, ST_DISPATCH, ST_WAIT_ACK,
    ST_WAIT_DONE, ST_ABORT, ST_RELEASE, ST_OUTPUT
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_sync;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [7:0]             hi_byte, hi_byte_d, lo_byte, lo_byte_d;
  logic                   byp, byp_d, last, last_d, captured, captured_d;
  logic                   in_ready_d, enc_start_d, out_valid_d, out_last_d, err_d;
  logic [15:0]            enc_data_d, out_word_d;
  logic                   in_fire, out_fire;

  assign done_sync         = sync_q[SYNC_STAGES-1];
  assign in_fire           = in_valid & in_ready;
  assign out_fire          = out_valid & out_ready;
  assign enc_passthrough_o = 1'b0;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hi_byte_d  = hi_byte;
    lo_byte_d  = lo_byte;
    byp_d      = byp;
    last_d     = last;
    captured_d = captured;
    enc_data_d = enc_data_o;
    out_word_d = out_word;
    out_last_d = out_last;
    err_d      = err_clr ? 1'b0 : err;

    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          hi_byte_d = in_byte;
          byp_d     = bypass;
          last_d    = in_last;
          if (in_last) begin
            lo_byte_d = PAD_BYTE;
            state_d   = ST_DISPATCH;
          end else begin
            state_d   = ST_FILL_LO;
          end
        end
      end
      ST_FILL_LO: begin
        if (in_fire) begin
          lo_byte_d = in_byte;
          last_d    = last | in_last;
          state_d   = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        captured_d = 1'b0;
        if (byp) begin
          out_word_d = {hi_byte, lo_byte};
          out_last_d = last;
          state_d    = ST_OUTPUT;
        end else begin
          enc_data_d = {hi_byte, lo_byte};
          cnt_d      = '0;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!done_sync) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt == CNT_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end else begin
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_sync) begin
          out_word_d = enc_result_i;
          out_last_d = last;
          captured_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RELEASE;
        end else if (cnt == CNT_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end else begin
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        err_d      = 1'b1;
        captured_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (cnt == CNT_REL_LAST) begin
          cnt_d   = '0;
          state_d = captured ? ST_OUTPUT : ST_IDLE;
        end else begin
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (out_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they flip on the transition edge
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_FILL_LO);
    enc_start_d = (state_d == ST_WAIT_ACK) || (state_d == ST_WAIT_DONE) || (state_d == ST_ABORT);
    out_valid_d = (state_d == ST_OUTPUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sync_q      <= '0;
      cnt         <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      byp         <= 1'b0;
      last        <= 1'b0;
      captured    <= 1'b0;
      in_ready    <= 1'b0;
      enc_data_o  <= '0;
      enc_start_o <= 1'b0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_last    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], enc_done_i};
      cnt         <= cnt_d;
      hi_byte     <= hi_byte_d;
      lo_byte     <= lo_byte_d;
      byp         <= byp_d;
      last        <= last_d;
      captured    <= captured_d;
      in_ready    <= in_ready_d;
      enc_data_o  <= enc_data_d;
      enc_start_o <= enc_start_d;
      out_valid   <= out_valid_d;
      out_word    <= out_word_d;
      out_last    <= out_last_d;
      err         <= err_d;
    end
  end

endmodule
